// File: rtl/seg_scan_driver.sv
// seg_scan_driver: eight-digit common-anode 7-segment scanner with shadow/active snapshot per frame.
// Optional SEG_LEADING_ZERO_BLANK_EN darkens digits above the most significant nonzero nibble.
module seg_scan_driver #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  en_in,
  input  logic        load,
  output logic        pending,
  output logic        frame_done,
  output logic [7:0]  SEG,
  output logic [7:0]  AN
);
  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  typedef logic [PW-1:0] pc_t;
  localparam pc_t PC_MAX = pc_t'(DIV - 1);
  localparam pc_t PC_BL  = pc_t'(BLANK_CYCLES);

  generate
    if (DIV < BLANK_CYCLES + 2) begin : g_bad_div
      $error("seg_scan_driver: CLK_HZ/SCAN_HZ must be at least BLANK_CYCLES+2");
    end
  endgenerate

  pc_t         pc_q, pc_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] sh_data_q, sh_data_d, ac_data_q, ac_data_d;
  logic [7:0]  sh_dp_q, sh_dp_d, ac_dp_q, ac_dp_d;
  logic [7:0]  sh_en_q, sh_en_d, ac_en_q, ac_en_d;
  logic        pending_q, pending_d, fd_q;
  logic [7:0]  seg_q, seg_d, an_q, an_d;
  logic        tick, boundary, lit;
  logic [7:0]  lz_show, vis;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // Blank mask derives from the active set only, so it can change only at a frame boundary.
  always_comb begin
    logic seen;
    seen    = 1'b0;
    lz_show = 8'h01;
    for (int k = 7; k >= 1; k--) begin
      seen       = seen | (|ac_data_q[4*k +: 4]);
      lz_show[k] = seen;
    end
  end
`else
  assign lz_show = 8'hFF;
`endif

  assign vis      = ac_en_q & lz_show;
  assign tick     = pc_q == PC_MAX;
  assign boundary = tick && idx_q == 3'd7;
  assign lit      = pc_q >= PC_BL && vis[idx_q];

  always_comb begin
    pc_d      = tick ? '0 : pc_q + pc_t'(1);
    idx_d     = tick ? idx_q + 3'd1 : idx_q;
    sh_data_d = load ? data_in : sh_data_q;
    sh_dp_d   = load ? dp_in : sh_dp_q;
    sh_en_d   = load ? en_in : sh_en_q;
    ac_data_d = (boundary && pending_q) ? sh_data_q : ac_data_q;
    ac_dp_d   = (boundary && pending_q) ? sh_dp_q : ac_dp_q;
    ac_en_d   = (boundary && pending_q) ? sh_en_q : ac_en_q;
    pending_d = load ? 1'b1 : (boundary ? 1'b0 : pending_q);
    an_d      = lit ? ~(8'd1 << idx_q) : 8'hFF;
    seg_d     = lit ? {~ac_dp_q[idx_q], hex7(ac_data_q[{idx_q, 2'b00} +: 4])} : 8'hFF;
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      pc_q      <= '0;
      idx_q     <= '0;
      sh_data_q <= '0;
      sh_dp_q   <= '0;
      sh_en_q   <= '0;
      ac_data_q <= '0;
      ac_dp_q   <= '0;
      ac_en_q   <= '0;
      pending_q <= 1'b0;
      fd_q      <= 1'b0;
      seg_q     <= 8'hFF;
      an_q      <= 8'hFF;
    end else begin
      pc_q      <= pc_d;
      idx_q     <= idx_d;
      sh_data_q <= sh_data_d;
      sh_dp_q   <= sh_dp_d;
      sh_en_q   <= sh_en_d;
      ac_data_q <= ac_data_d;
      ac_dp_q   <= ac_dp_d;
      ac_en_q   <= ac_en_d;
      pending_q <= pending_d;
      fd_q      <= boundary;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign pending    = pending_q;
  assign frame_done = fd_q;
  assign SEG        = seg_q;
  assign AN         = an_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: random and directed stimulus against a frame-arithmetic reference model.
module tb_seg_scan_driver;
  localparam int DIV = 8;
  localparam int BL  = 2;
  localparam int FR  = 8 * DIV;
  localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data = '0;
  logic [7:0]  dp = '0, en = '0;
  logic        ld = 1'b0;
  logic        pend, fd;
  logic [7:0]  seg, an;

  logic [31:0] m_sd, m_ad;
  logic [7:0]  m_sdp, m_adp, m_sen, m_aen;
  logic        m_pend;
  int          k;
  int          n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.CLK_HZ(80), .SCAN_HZ(10), .BLANK_CYCLES(BL)) dut (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .data_in(data), .dp_in(dp), .en_in(en),
    .load(ld), .pending(pend), .frame_done(fd), .SEG(seg), .AN(an)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at k=%0d: got %h expected %h", tag, k, got, exp);
    end
  endtask

  function automatic bit shown(input int dig);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    int msd = 0;
    for (int j = 0; j < 8; j++) if (((m_ad >> (4 * j)) & 32'hF) != 0) msd = j;
    return dig <= msd;
`else
    return dig >= 0;
`endif
  endfunction

  task automatic model_reset();
    k = 0;
    m_sd = '0; m_ad = '0; m_sdp = '0; m_adp = '0; m_sen = '0; m_aen = '0; m_pend = 1'b0;
  endtask

  task automatic step(input logic l, input logic [31:0] d, input logic [7:0] p, input logic [7:0] e);
    int s, pos, dig;
    bit on, bnd;
    logic [7:0] e_an, e_seg;
    ld = l; data = d; dp = p; en = e;
    @(posedge clk);
    k++;
    s   = (k - 1) % FR;
    pos = s % DIV;
    dig = s / DIV;
    on  = pos >= BL && m_aen[dig] && shown(dig);
    e_an  = on ? ~(8'd1 << dig) : 8'hFF;
    e_seg = on ? {~m_adp[dig], HEX[(m_ad >> (4 * dig)) & 32'hF][6:0]} : 8'hFF;
    bnd = (k % FR) == 0;
    if (bnd && m_pend) begin
      m_ad = m_sd; m_adp = m_sdp; m_aen = m_sen; m_pend = 1'b0;
    end
    if (l) begin
      m_sd = d; m_sdp = p; m_sen = e; m_pend = 1'b1;
    end
    #1;
    chk("AN", 32'(an), 32'(e_an));
    chk("SEG", 32'(seg), 32'(e_seg));
    chk("pending", 32'(pend), 32'(m_pend));
    chk("frame_done", 32'(fd), 32'(bnd));
    ld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, $urandom, 8'($urandom), 8'($urandom));
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_AN", 32'(an), 32'hFF);
    chk("rst_SEG", 32'(seg), 32'hFF);
    chk("rst_pending", 32'(pend), 32'h0);
    chk("rst_frame_done", 32'(fd), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3 * FR);
    step(1'b1, 32'h89ABCDEF, 8'h01, 8'hFF);
    idle(2 * FR + 10);
    while (((k + 1) % FR) != 10) idle(1);
    step(1'b1, 32'h11111111, 8'h00, 8'hFF);
    while (((k + 1) % FR) != 0) idle(1);
    step(1'b1, 32'h22222222, 8'h00, 8'hFF);
    chk("pending_after_bnd_load", 32'(pend), 32'h1);
    idle(2 * FR + 5);
    step(1'b1, $urandom, 8'($urandom), 8'h5A);
    idle(2 * FR);
    repeat (600) step($urandom_range(0, 15) == 0, $urandom, 8'($urandom), 8'($urandom));
    step(1'b1, 32'h00000305, 8'h00, 8'hFF);
    idle(2 * FR);
    step(1'b1, 32'h00000000, 8'h00, 8'hFF);
    idle(2 * FR);
    step(1'b1, 32'h76543210, 8'h20, 8'hFF);
    idle(2 * FR);
    while (((k - 1) % FR) != 5 * DIV + 4) idle(1);
    chk("digit5_lit", 32'(an), 32'hDF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_AN", 32'(an), 32'hFF);
    chk("async_SEG", 32'(seg), 32'hFF);
    chk("async_pending", 32'(pend), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle(FR + 6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
